// File: rtl/integral_pkg.sv
// Shared types and defaults for the integral image writer.
package integral_pkg;

    // Writer sequencing states
    typedef enum logic [1:0] {
        Idle,
        Run,
        Drain,
        Finish
    } iiState_t;

    localparam int unsigned DefImgWidth  = 320;
    localparam int unsigned DefImgHeight = 240;
    localparam int unsigned DefPixBits   = 8;
    localparam int unsigned DefIiBits    = 32;
    localparam int unsigned DefAddrInc   = 4;
    localparam int unsigned DefFifoDepth = 16;

    // One pending SDRAM write: byte address plus integral value
    typedef struct packed {
        logic [31:0]           addr;
        logic [DefIiBits-1:0]  data;
    } iiEntry_t;

endpackage

// File: rtl/ii_out_fifo.sv
// Synchronous show-ahead FIFO holding pending integral writes.
module ii_out_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oFull,
    output logic             oEmpty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign oEmpty = (count == '0);
    assign oFull  = (count == (AW+1)'(DEPTH));
    assign doPop  = iPop && !oEmpty;
    // A push into a full FIFO still lands when the head leaves the same cycle
    assign doPush = iPush && (!oFull || doPop);
    assign oData  = mem[rdPtr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, contents need no reset
    always_ff @(posedge iClk) begin
        if (doPush) mem[wrPtr] <= iData;
    end

endmodule

// File: rtl/integral_image_writer.sv
// Streams pixels into integral-image values and queues one SDRAM write per pixel.
module integral_image_writer
    import integral_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DefImgWidth,
    parameter int unsigned IMG_HEIGHT = DefImgHeight,
    parameter int unsigned PIX_BITS   = DefPixBits,
    parameter int unsigned II_BITS    = DefIiBits,
    parameter int unsigned ADDR_INC   = DefAddrInc,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic [31:0] iDest_address,
    input  logic        iOutput_ready,
    input  logic [31:0] iData_in,
    input  logic        iWrite_wait_request,
    output logic        oWrreq_SDRAM,
    output logic [31:0] oAddr_SDRAM,
    output logic [31:0] oData_to_SDRAM,
    output logic        oFinish,
    output logic        oBusy,
    output logic        oOverflow
);
    localparam int unsigned XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned EW = 32 + II_BITS;

    iiState_t           stateQ, stateD;
    logic [XW-1:0]      xQ;
    logic [YW-1:0]      yQ;
    logic [31:0]        addrQ;
    logic [II_BITS-1:0] rowSumQ;
    logic               overflowQ;

    // Stage 1: pixel accepted last cycle, row-buffer word already read
    logic               s1ValidQ;
    logic [XW-1:0]      s1XQ;
    logic               s1YZeroQ;
    logic [31:0]        s1AddrQ;
    logic [II_BITS-1:0] rbRdQ;

    logic [II_BITS-1:0] rowBuf [IMG_WIDTH];

    logic               accept;
    logic               lastX;
    logic               lastY;
    logic [II_BITS-1:0] pixExt;
    logic [II_BITS-1:0] iiVal;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               fifoPop;
    logic [EW-1:0]      fifoHead;
    logic [31:0]        dataExt;
    logic               unusedData;

    assign unusedData = ^iData_in[31:PIX_BITS];

    assign accept  = (stateQ == Run) && iOutput_ready;
    assign lastX   = (xQ == XW'(IMG_WIDTH - 1));
    assign lastY   = (yQ == YW'(IMG_HEIGHT - 1));
    assign iiVal   = rowSumQ + (s1YZeroQ ? '0 : rbRdQ);
    assign fifoPop = !fifoEmpty && !iWrite_wait_request;

    // Zero-extend pixel into the integral width and the result onto the bus
    always_comb begin
        pixExt = '0;
        pixExt[PIX_BITS-1:0] = iData_in[PIX_BITS-1:0];
        dataExt = '0;
        dataExt[II_BITS-1:0] = fifoHead[II_BITS-1:0];
    end

    // State register
    always_ff @(posedge iClk) begin
        if (!iReset_n) stateQ <= Idle;
        else           stateQ <= stateD;
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            Idle:    if (iStart) stateD = Run;
            Run:     if (accept && lastX && lastY) stateD = Drain;
            Drain:   if (!s1ValidQ && fifoEmpty) stateD = Finish;
            Finish:  stateD = Idle;
            default: stateD = Idle;
        endcase
    end

    // Raster position, running address and running row sum
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            xQ      <= '0;
            yQ      <= '0;
            addrQ   <= '0;
            rowSumQ <= '0;
        end else if (stateQ == Idle && iStart) begin
            xQ      <= '0;
            yQ      <= '0;
            addrQ   <= iDest_address;
            rowSumQ <= '0;
        end else if (accept) begin
            rowSumQ <= ((xQ == '0) ? '0 : rowSumQ) + pixExt;
            addrQ   <= addrQ + 32'(ADDR_INC);
            if (lastX) begin
                xQ <= '0;
                yQ <= lastY ? '0 : yQ + 1'b1;
            end else begin
                xQ <= xQ + 1'b1;
            end
        end
    end

    // Stage-1 control and address capture
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            s1ValidQ <= 1'b0;
            s1XQ     <= '0;
            s1YZeroQ <= 1'b0;
            s1AddrQ  <= '0;
        end else begin
            s1ValidQ <= accept;
            s1XQ     <= xQ;
            s1YZeroQ <= (yQ == '0);
            s1AddrQ  <= addrQ;
        end
    end

    // Row buffer: read column above on accept, write back the new integral a cycle later
    always_ff @(posedge iClk) begin
        if (accept)   rbRdQ <= rowBuf[xQ];
        if (s1ValidQ) rowBuf[s1XQ] <= iiVal;
    end

    // Sticky overflow: a result arrived with the FIFO full and nothing leaving
    always_ff @(posedge iClk) begin
        if (!iReset_n)                         overflowQ <= 1'b0;
        else if (stateQ == Idle && iStart)     overflowQ <= 1'b0;
        else if (s1ValidQ && fifoFull && !fifoPop) overflowQ <= 1'b1;
    end

    ii_out_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iPush    (s1ValidQ),
        .iData    ({s1AddrQ, iiVal}),
        .iPop     (fifoPop),
        .oData    (fifoHead),
        .oFull    (fifoFull),
        .oEmpty   (fifoEmpty)
    );

    assign oWrreq_SDRAM   = !fifoEmpty;
    assign oAddr_SDRAM    = fifoEmpty ? 32'h0 : fifoHead[EW-1:II_BITS];
    assign oData_to_SDRAM = fifoEmpty ? 32'h0 : dataExt;
    assign oFinish        = (stateQ == Finish);
    assign oBusy          = (stateQ != Idle);
    assign oOverflow      = overflowQ;

endmodule

// File: tb/tb_integral_image_writer.sv
// Self-checking bench: two writer instances (4x3 and 8x4) against a frame-level model.
module tb_integral_image_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstn, start, ready, stall;
    logic [1:0][31:0] base, din;
    logic [1:0]       wrreq, fin, busy, ovf;
    logic [1:0][31:0] oa, od;

    integral_image_writer #(
        .IMG_WIDTH (4), .IMG_HEIGHT (3), .PIX_BITS (8), .II_BITS (32),
        .ADDR_INC (4), .FIFO_DEPTH (16)
    ) dut0 (
        .iClk (clk), .iReset_n (rstn[0]), .iStart (start[0]),
        .iDest_address (base[0]), .iOutput_ready (ready[0]), .iData_in (din[0]),
        .iWrite_wait_request (stall[0]), .oWrreq_SDRAM (wrreq[0]),
        .oAddr_SDRAM (oa[0]), .oData_to_SDRAM (od[0]), .oFinish (fin[0]),
        .oBusy (busy[0]), .oOverflow (ovf[0])
    );

    integral_image_writer #(
        .IMG_WIDTH (8), .IMG_HEIGHT (4), .PIX_BITS (8), .II_BITS (32),
        .ADDR_INC (4), .FIFO_DEPTH (16)
    ) dut1 (
        .iClk (clk), .iReset_n (rstn[1]), .iStart (start[1]),
        .iDest_address (base[1]), .iOutput_ready (ready[1]), .iData_in (din[1]),
        .iWrite_wait_request (stall[1]), .oWrreq_SDRAM (wrreq[1]),
        .oAddr_SDRAM (oa[1]), .oData_to_SDRAM (od[1]), .oFinish (fin[1]),
        .oBusy (busy[1]), .oOverflow (ovf[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state per instance
    int          mW [2] = '{4, 8};
    int          mH [2] = '{3, 4};
    int          phase [2];            // 0 idle, 1 run, 2 drain, 3 finish
    logic        mOvf [2];
    logic [31:0] mBase [2];
    int          mCnt [2];
    logic [31:0] img [2][0:31];
    logic        pendV [2];
    logic [63:0] pend [2];
    logic [63:0] mq [2][0:15];
    int          qh [2];
    int          qn [2];
    logic        prevStall [2];
    logic [31:0] prevA [2];
    logic [31:0] prevD [2];
    int          wrCount [2];
    logic [31:0] lastA [2];
    logic [31:0] lastD [2];
    int          firstWrCyc [2];
    logic [31:0] firstWrA [2];
    int          finCount [2];
    int          firstPixCyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Integral = plain double sum over everything above-left inclusive
    function automatic logic [31:0] iiOf(input int d, input int x, input int y);
        logic [31:0] s = 0;
        for (int j = 0; j <= y; j++)
            for (int i = 0; i <= x; i++)
                s += img[d][j*mW[d] + i];
        return s;
    endfunction

    task automatic modelReset(input int d);
        phase[d] = 0; mOvf[d] = 1'b0; mCnt[d] = 0; pendV[d] = 1'b0;
        qh[d] = 0; qn[d] = 0; prevStall[d] = 1'b0;
    endtask

    // Compare current outputs with the model, then advance the model over the coming edge
    task automatic step(input int d);
        logic pop, acc;
        int x, y;
        chk($sformatf("d%0d_wrreq", d), {31'b0, wrreq[d]}, {31'b0, (qn[d] > 0)});
        if (qn[d] > 0) begin
            chk($sformatf("d%0d_addr", d), oa[d], mq[d][qh[d]][63:32]);
            chk($sformatf("d%0d_data", d), od[d], mq[d][qh[d]][31:0]);
        end
        if (prevStall[d]) begin
            chk($sformatf("d%0d_stall_addr_stable", d), oa[d], prevA[d]);
            chk($sformatf("d%0d_stall_data_stable", d), od[d], prevD[d]);
        end
        chk($sformatf("d%0d_busy", d), {31'b0, busy[d]}, {31'b0, (phase[d] != 0)});
        chk($sformatf("d%0d_finish", d), {31'b0, fin[d]}, {31'b0, (phase[d] == 3)});
        chk($sformatf("d%0d_overflow", d), {31'b0, ovf[d]}, {31'b0, mOvf[d]});

        if (wrreq[d] && !stall[d]) begin
            wrCount[d]++; lastA[d] = oa[d]; lastD[d] = od[d];
        end
        if (wrreq[d] && firstWrCyc[d] < 0) begin
            firstWrCyc[d] = cyc; firstWrA[d] = oa[d];
        end
        if (fin[d]) finCount[d]++;
        prevStall[d] = wrreq[d] && stall[d];
        prevA[d] = oa[d];
        prevD[d] = od[d];

        if (!rstn[d]) begin
            modelReset(d);
        end else begin
            acc = (phase[d] == 1) && ready[d];
            pop = (qn[d] > 0) && !stall[d];
            case (phase[d])
                0: if (start[d]) begin
                       phase[d] = 1; mOvf[d] = 1'b0; mBase[d] = base[d]; mCnt[d] = 0;
                   end
                1: if (acc && mCnt[d] == mW[d]*mH[d] - 1) phase[d] = 2;
                2: if (!pendV[d] && qn[d] == 0) phase[d] = 3;
                default: phase[d] = 0;
            endcase
            if (pop) begin
                qh[d] = (qh[d] + 1) % 16;
                qn[d]--;
            end
            if (pendV[d]) begin
                if (qn[d] < 16) begin
                    mq[d][(qh[d] + qn[d]) % 16] = pend[d];
                    qn[d]++;
                end else begin
                    mOvf[d] = 1'b1;
                end
            end
            pendV[d] = acc;
            if (acc) begin
                x = mCnt[d] % mW[d];
                y = mCnt[d] / mW[d];
                img[d][mCnt[d]] = din[d] & 32'hFF;
                pend[d] = {mBase[d] + 32'(mCnt[d]*4), iiOf(d, x, y)};
                mCnt[d]++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) step(d);
    end

    function automatic logic [31:0] pix(input int mode);
        case (mode)
            0:       return 32'h1;
            1:       return 32'hFFFF_FF05;
            default: return $urandom;
        endcase
    endfunction

    // One full frame with optional input gaps and a write-side stall window
    task automatic runFrame(input int d, input int mode, input logic [31:0] b,
                            input int stallAt, input int stallLen, input int gapPct);
        int sent = 0;
        int k = 0;
        int n = mW[d] * mH[d];
        wrCount[d] = 0; finCount[d] = 0; firstWrCyc[d] = -1; firstPixCyc = -1;
        base[d] = b; start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        while (finCount[d] == 0 && k < 2000) begin
            stall[d] = (k >= stallAt) && (k < stallAt + stallLen);
            if (sent < n && $urandom_range(99) >= gapPct) begin
                ready[d] = 1'b1; din[d] = pix(mode);
                if (sent == 0) firstPixCyc = cyc;
                sent++;
            end else begin
                ready[d] = 1'b0; din[d] = $urandom;
            end
            @(posedge clk); #1;
            k++;
        end
        ready[d] = 1'b0; stall[d] = 1'b0;
        if (finCount[d] == 0) chk($sformatf("d%0d_finish_timeout", d), 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 2'b00; start = '0; ready = '0; stall = '0; base = '0; din = '0;
        for (int d = 0; d < 2; d++) begin
            modelReset(d);
            wrCount[d] = 0; finCount[d] = 0; firstWrCyc[d] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wrreq", {30'b0, wrreq}, 32'd0);
        chk("reset_addr", oa[0] | oa[1], 32'd0);
        chk("reset_data", od[0] | od[1], 32'd0);
        chk("reset_busy", {30'b0, busy}, 32'd0);
        chk("reset_finish", {30'b0, fin}, 32'd0);
        chk("reset_overflow", {30'b0, ovf}, 32'd0);
        rstn = 2'b11;
        @(posedge clk); #1;

        // All-ones 4x3 frame: ii(x,y) = (x+1)(y+1)
        runFrame(0, 0, 32'h1000, 0, 0, 0);
        chk("ones_write_count", wrCount[0], 32'd12);
        chk("ones_last_addr", lastA[0], 32'h102C);
        chk("ones_last_data", lastD[0], 32'd12);
        chk("ones_finish_count", finCount[0], 32'd1);

        // Upper pixel bits ignored: behaves as all-5
        runFrame(0, 1, 32'h1000, 0, 0, 0);
        chk("five_write_count", wrCount[0], 32'd12);
        chk("five_last_data", lastD[0], 32'd60);

        // First-write latency into an idle pipeline, with input gaps
        runFrame(0, 2, 32'h0000_2000, 0, 0, 50);
        chk("latency_cycles", 32'(firstWrCyc[0] - firstPixCyc), 32'd2);
        chk("latency_addr", firstWrA[0], 32'h2000);

        // 8x4 continuous stream against a 30-cycle stall: FIFO overflows
        runFrame(1, 2, 32'h0004_0000, 0, 30, 0);
        chk("stall30_overflow", {31'b0, ovf[1]}, 32'd1);
        chk("stall30_finish_count", finCount[1], 32'd1);
        runFrame(1, 2, 32'h0005_0000, 0, 0, 0);
        chk("restart_clears_overflow", {31'b0, ovf[1]}, 32'd0);
        chk("restart_write_count", wrCount[1], 32'd32);

        // 10-cycle stall on 4x3 fits in the FIFO
        runFrame(0, 2, 32'hFFFF_FFF0, 3, 10, 0);
        chk("stall10_overflow", {31'b0, ovf[0]}, 32'd0);
        chk("stall10_write_count", wrCount[0], 32'd12);

        // Reset in the middle of row 1 with writes still queued
        base[0] = 32'h3000; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; stall[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ready[0] = 1'b1; din[0] = $urandom;
            @(posedge clk); #1;
        end
        ready[0] = 1'b0; rstn[0] = 1'b0;
        @(posedge clk); #1;
        chk("midreset_wrreq", {31'b0, wrreq[0]}, 32'd0);
        chk("midreset_addr", oa[0], 32'd0);
        chk("midreset_data", od[0], 32'd0);
        chk("midreset_busy", {31'b0, busy[0]}, 32'd0);
        chk("midreset_finish", {31'b0, fin[0]}, 32'd0);
        rstn[0] = 1'b1; stall[0] = 1'b0;
        @(posedge clk); #1;
        runFrame(0, 2, 32'h3000, 0, 0, 0);
        chk("after_reset_count", wrCount[0], 32'd12);

        // Mixed random frames
        for (int r = 0; r < 4; r++) begin
            runFrame(r % 2, 2, $urandom & 32'hFFFF_FFFC, int'($urandom_range(20)),
                     int'($urandom_range(12)), int'($urandom_range(40)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/integral_image_writer.md
# integral_image_writer

Core-side stage downstream of the SDRAM DMA controller: consumes the pixel stream delivered on the controller's read side (valid strobe + 32-bit word), computes the Viola-Jones integral image ii(x,y) = Σ pixels above-left inclusive, and issues one SDRAM write per pixel through the controller's core write port (request/address/data, wait-request backpressure, finish strobe). It buffers results so read-side bursts, which cannot be stalled, survive write-side wait-requests.

## Interface
- IMG_WIDTH, 320: pixels per row (≥2).
- IMG_HEIGHT, 240: rows per frame (≥1).
- PIX_BITS, 8: pixel width, taken from iData_in[PIX_BITS-1:0].
- II_BITS, 32: integral width; must be ≥ PIX_BITS + clog2(IMG_WIDTH*IMG_HEIGHT).
- ADDR_INC, 4: byte step between consecutive integral words.
- FIFO_DEPTH, 16: output FIFO entries (power of 2).

- iClk  in  1  single clock; everything samples on rising edge.
- iReset_n  in  1  reset, synchronous, active-low.
- iStart  in  1  one-cycle frame start; honoured only in IDLE.
- iDest_address  in  32  byte base address of the frame, latched on iStart.
- iOutput_ready  in  1  pixel word valid this cycle; no backpressure possible.
- iData_in  in  32  pixel word; upper bits ignored.
- iWrite_wait_request  in  1  core write port stall.
- oWrreq_SDRAM  out  1  write request.
- oAddr_SDRAM  out  32  write byte address.
- oData_to_SDRAM  out  32  integral value, zero-extended from II_BITS.
- oFinish  out  1  one-cycle pulse: frame fully written.
- oBusy  out  1  high in any state except IDLE.
- oOverflow  out  1  sticky: a result was dropped on full FIFO.

## Operation
- States: IDLE → RUN on iStart (latch base, x=y=0, row_sum=0, clear oOverflow). RUN → DRAIN when pixel (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted. DRAIN → FINISH when pipeline empty and FIFO empty and no write outstanding. FINISH → IDLE after one cycle (oFinish high in FINISH only).
- iOutput_ready outside RUN is ignored; iStart outside IDLE is ignored.
- Per accepted pixel p at (x,y): row_sum' = (x==0 ? 0 : row_sum) + p; ii = row_sum' + (y==0 ? 0 : rowbuf[x]); rowbuf[x] ← ii. rowbuf is IMG_WIDTH×II_BITS, one read and one write per pixel; never needs clearing (y==0 masks it).
- Address = base + (y*IMG_WIDTH + x)*ADDR_INC, computed by a running counter (add ADDR_INC per pixel), mod 2^32, no multiplier.
- Push {addr, ii} into FIFO. oWrreq_SDRAM = FIFO non-empty; head popped on cycle where oWrreq_SDRAM && ~iWrite_wait_request. Address/data stable while stalled.
- Push when full: entry dropped, oOverflow set until next accepted iStart; frame counting continues so DRAIN/FINISH still occur.
- x wraps to 0 and y increments after x==IMG_WIDTH-1.

## Timing
- Reset values: oWrreq_SDRAM 0, oAddr_SDRAM 0, oData_to_SDRAM 0, oFinish 0, oBusy 0, oOverflow 0; FSM IDLE, FIFO empty, counters 0.
- Pixel valid in cycle t → FIFO write at end of t+1 → oWrreq_SDRAM high in t+2 if FIFO was empty. Throughput one pixel per cycle.
- Back-to-back pixels with RAW on rowbuf: different x each cycle, so no forwarding needed; IMG_WIDTH≥2 guarantees it.
- oFinish earliest 1 cycle after last write accepted.
- Simultaneous push and pop on full FIFO: both succeed, no overflow.
- Reset mid-frame: next cycle all outputs at reset values, FIFO contents discarded, no oFinish.

## Structure
- Package integral_pkg: state enum (IDLE, RUN, DRAIN, FINISH), default widths, ADDR_INC constant, FIFO entry type {addr[31:0], data[II_BITS-1:0]}.
- Sub-module ii_out_fifo: synchronous show-ahead FIFO, FIFO_DEPTH entries, full/empty flags. Row buffer inferred as simple dual-port RAM in the top.

## Test plan
- W=4,H=3, all pixels 1, base 0x1000, no stalls → 12 writes, data (x+1)(y+1), last write addr 0x102C data 12, oFinish once.
- Same frame, pixels = 0xFFFFFF05 → upper bits ignored, identical to all-5 frame (last data 60).
- Pixel on cycle t into idle pipeline → oWrreq_SDRAM first high on t+2 with addr=base.
- iWrite_wait_request held high 30 cycles during W=8,H=4 continuous stream, FIFO_DEPTH 16 → oOverflow=1, stalled addr/data stable, oFinish still pulses; next iStart clears oOverflow.
- Stall 10 cycles with FIFO_DEPTH 16, W=4,H=3 → no overflow, all 12 words correct in order.
- Reset asserted mid-row 1 → outputs zero next cycle; fresh iStart frame produces correct values from y=0.
